// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Iterative radix-2 restoring divider. Signed (two's-complement)
//               by default. A WIDTH-bit dividend and divisor give a quotient
//               truncated toward zero and a remainder with the dividend's
//               sign, WIDTH+2 clocks after start.
//               Optional macro DIVIDER_SIGNED_SEL_EN adds input `sgn`, which
//               selects signed (1) or unsigned (0) division at start.
// Ports       : clk   - clock, all state on posedge
//               rst   - synchronous active-high reset
//               sgn   - signed select (only with DIVIDER_SIGNED_SEL_EN)
//               start - request, a/b sampled on the same edge while idle
//               a, b  - dividend, divisor
//               busy  - operation in progress, start ignored while high
//               done  - one-cycle pulse, q/r/dbz valid from this cycle
//               q, r  - quotient, remainder (held until next completion)
//               dbz   - divide-by-zero flag of last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DIVIDER_SIGNED_SEL_EN
    input  logic             sgn,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_bmag;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH:0]       r_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_r;
    logic                 r_dbz;
    logic                 r_done;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_fits;

`ifdef DIVIDER_SIGNED_SEL_EN
    assign w_signed = sgn;
`else
    assign w_signed = 1'b1;
`endif

    // In unsigned mode the sign flags stay clear, so magnitudes are the raw
    // operands and the fix-up step leaves the results untouched.
    // Negating the most negative value yields 2^(WIDTH-1), which is still
    // correct when read as an unsigned magnitude.
    assign w_a_neg = w_signed & a[WIDTH-1];
    assign w_b_neg = w_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // One restoring step: shift {R,Q} left, trial-subtract |b| with an extra
    // borrow bit; a clear borrow means the subtraction is kept.
    assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_bmag};
    assign w_fits  = ~w_diff[WIDTH+1];

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;
    assign dbz  = r_dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_bmag  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_bmag  <= w_b_mag;
                        r_quo   <= w_a_mag;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_fits) begin
                        r_rem <= w_diff[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift;
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (r_neg_q) r_quo <= -r_quo;
                    if (r_neg_r) r_rem <= -r_rem;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    // A zero magnitude means a zero divisor; the iterated
                    // result is discarded in favour of the fixed dbz answer.
                    if (r_bmag == '0) begin
                        r_q   <= '1;
                        r_r   <= r_a;
                        r_dbz <= 1'b1;
                    end else begin
                        r_q   <= r_quo;
                        r_r   <= r_rem[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Self-checking bench for divider (WIDTH=8). Expected results
//               are queued when an operation is issued and popped when done
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
`ifdef DIVIDER_SIGNED_SEL_EN
    logic       sgn;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_fail  = 0;

    divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef DIVIDER_SIGNED_SEL_EN
        .sgn   (sgn),
`endif
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed reference: truncating division on ints, wrapped to 8 bits.
    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib);
        exp_t e;
        int   sa;
        int   sbv;
        int   qi;
        int   ri;
        if (ib == 8'h00) begin
            e.q = 8'hFF; e.r = ia; e.dbz = 1'b1;
        end else begin
            sa  = int'($signed(ia));
            sbv = int'($signed(ib));
            qi  = sa / sbv;
            ri  = sa % sbv;
            e.q = qi[7:0]; e.r = ri[7:0]; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Issue one operation and check it. With hold_junk, start stays high
    // with random operands during most of the busy window.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input bit hold_junk);
        exp_t e;
        int   cyc;
        sb.push_back('{q: eq, r: er, dbz: edbz});
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            chk("busy_during_op", {31'd0, busy}, 32'd1);
            start = hold_junk && (cyc < 7);
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, 32'd10);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        e = sb.pop_front();
        chk("q", {24'd0, q}, {24'd0, e.q});
        chk("r", {24'd0, r}, {24'd0, e.r});
        chk("dbz", {31'd0, dbz}, {31'd0, e.dbz});
    endtask

    initial begin
        int   seen;
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
`ifdef DIVIDER_SIGNED_SEL_EN
        sgn = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_r", {24'd0, r}, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic + one-cycle done + hold
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("q_hold", {24'd0, q}, 32'd14);
        chk("r_hold", {24'd0, r}, 32'd2);

        // Signs, issued back-to-back in the done cycle
        run_op(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0);
        run_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
        run_op(8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, 1'b0);

        // Overflow and most-negative dividend
        run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);

        // Divide by zero, then a normal op clears dbz
        run_op(8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1'b0);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);

        // start held while busy with other operands is ignored
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("junk_no_second_op", {31'd0, busy}, 32'd0);

        // Reset mid-operation
        a = 8'd20; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_q", {24'd0, q}, 32'd0);
        chk("midrst_r", {24'd0, r}, 32'd0);
        chk("midrst_dbz", {31'd0, dbz}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("midrst_no_done", seen, 32'd0);

`ifdef DIVIDER_SIGNED_SEL_EN
        sgn = 1'b0;
        run_op(8'hC8, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
        sgn = 1'b1;
        run_op(8'hC8, 8'd7, 8'hF8, 8'h00, 1'b0, 1'b0);
`endif

        // Random signed operands against the reference model
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 3) rb = 8'h00;
            e = model(ra, rb);
            run_op(ra, rb, e.q, e.r, e.dbz, 1'b0);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
`default_nettype wire
